// File: rtl/ysyx_22051145_gpr_dump.sv
// GPR dump sequencer: walks the register file through one read port
// and streams each value out over a valid/ready handshake.
module ysyx_22051145_gpr_dump #(
    parameter int NREGS = 32,
    parameter int XLEN  = 64,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [AW-1:0]   rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_idx,
    output logic [XLEN-1:0] out_data,
    output logic            out_last,
    output logic            busy,
    output logic            core_stall,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_nxt;
    logic          hs;

    assign hs = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (abort) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = READ;
                        idx_nxt   = '0;
                    end
                end
                READ: state_nxt = SEND;
                SEND: begin
                    if (hs) begin
                        if (idx == LAST) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = READ;
                            idx_nxt   = idx + AW'(1);
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            // abort leaves out_data/out_idx as the last captured beat
            if (abort) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (state == READ) begin
                out_valid <= 1'b1;
                out_data  <= rf_rdata;
                out_idx   <= idx;
                out_last  <= (idx == LAST);
            end else if (state == SEND && hs) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign rf_raddr   = idx;
    assign busy       = (state != IDLE);
    assign core_stall = busy;
    assign done       = (state == DONE);

endmodule
